// File: rtl/psum_normalizer.sv
// psum_normalizer: per-element q = min(|psum| * 2^Q_BW / sum, 2^Q_BW-1) using one shared
// restoring divider (one quotient bit per cycle), valid/ready handshakes on both sides.
module psum_normalizer #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 12,
    parameter int SUM_BW  = 19,
    parameter int Q_BW    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_sign_mode,
    input  logic [COL*BW_PSUM-1:0] i_in_psum,
    input  logic [SUM_BW-1:0]      i_in_sum,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    output logic [COL*Q_BW-1:0]    o_out_q,
    output logic                   o_out_div0,
    output logic                   o_out_valid,
    input  logic                   i_out_ready
);

    localparam int D     = BW_PSUM + Q_BW;
    localparam int CNT_W = $clog2(D);
    localparam int IDX_W = (COL > 1) ? $clog2(COL) : 1;

    // S_IDLE: accept a vector | S_DIV: one quotient bit per cycle | S_DONE: hold result
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [COL*BW_PSUM-1:0]   r_psum;
    logic [SUM_BW-1:0]        r_sum;
    logic                     r_sign;
    logic [IDX_W-1:0]         r_idx;
    logic [SUM_BW:0]          r_rem;
    logic [D-1:0]             r_quo;
    logic [CNT_W-1:0]         r_bitcnt;
    logic [COL*Q_BW-1:0]      r_out_q;
    logic                     r_div0;

    logic                     w_accept;
    logic                     w_sum_zero;
    logic                     w_last_step;
    logic                     w_last_elem;
    logic [BW_PSUM-1:0]       w_elem;
    logic [BW_PSUM-1:0]       w_operand;
    logic [D-1:0]             w_dividend;
    logic [SUM_BW+1:0]        w_rem_shift;
    logic [SUM_BW+1:0]        w_rem_nxt;
    logic                     w_ge;
    logic [D-1:0]             w_quo_nxt;
    logic [Q_BW-1:0]          w_q;

    assign o_in_ready  = (r_state == S_IDLE) && !i_reset;
    assign o_out_valid = (r_state == S_DONE);
    assign o_out_q     = r_out_q;
    assign o_out_div0  = r_div0;

    assign w_accept    = o_in_ready && i_in_valid;
    assign w_sum_zero  = (i_in_sum == '0);
    assign w_last_step = (r_bitcnt == '0);
    assign w_last_elem = (r_idx == IDX_W'(COL - 1));

    // Two's complement magnitude fits in BW_PSUM bits even for the most negative value
    assign w_elem      = r_psum[r_idx*BW_PSUM +: BW_PSUM];
    assign w_operand   = (r_sign && w_elem[BW_PSUM-1]) ? (~w_elem + BW_PSUM'(1)) : w_elem;
    assign w_dividend  = {w_operand, {Q_BW{1'b0}}};

    assign w_rem_shift = {r_rem, w_dividend[r_bitcnt]};
    assign w_ge        = (w_rem_shift >= (SUM_BW+2)'(r_sum));
    assign w_rem_nxt   = w_ge ? (w_rem_shift - (SUM_BW+2)'(r_sum)) : w_rem_shift;

    always_comb begin
        w_quo_nxt           = r_quo;
        w_quo_nxt[r_bitcnt] = w_ge;
    end

    assign w_q = (|w_quo_nxt[D-1:Q_BW]) ? {Q_BW{1'b1}} : w_quo_nxt[Q_BW-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_sum_zero ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (w_last_step && w_last_elem) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_psum   <= '0;
            r_sum    <= '0;
            r_sign   <= 1'b0;
            r_idx    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_bitcnt <= '0;
            r_out_q  <= '0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_psum   <= i_in_psum;
                        r_sum    <= i_in_sum;
                        r_sign   <= i_sign_mode;
                        r_idx    <= '0;
                        r_rem    <= '0;
                        r_quo    <= '0;
                        r_bitcnt <= CNT_W'(D - 1);
                        if (w_sum_zero) begin
                            r_out_q <= '1;
                            r_div0  <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= (SUM_BW+1)'(w_rem_nxt);
                    if (w_last_step) begin
                        r_out_q[r_idx*Q_BW +: Q_BW] <= w_q;
                        if (w_last_elem) begin
                            r_div0 <= 1'b0;
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                            r_rem    <= '0;
                            r_quo    <= '0;
                            r_bitcnt <= CNT_W'(D - 1);
                        end
                    end else begin
                        r_quo    <= w_quo_nxt;
                        r_bitcnt <= r_bitcnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_normalizer.sv
// Directed bench for psum_normalizer: expected results from an arithmetic reference model are
// queued at acceptance and popped when the result handshakes out.
module tb_psum_normalizer;

    localparam int COL = 8;
    localparam int BW  = 12;
    localparam int SBW = 19;
    localparam int QBW = 8;
    localparam int D   = BW + QBW;

    typedef struct {
        logic [COL*QBW-1:0] q;
        logic               div0;
        int                 lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                i_reset;
    logic                i_sign_mode;
    logic [COL*BW-1:0]   i_in_psum;
    logic [SBW-1:0]      i_in_sum;
    logic                i_in_valid;
    logic                o_in_ready;
    logic [COL*QBW-1:0]  o_out_q;
    logic                o_out_div0;
    logic                o_out_valid;
    logic                i_out_ready;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    psum_normalizer #(.COL(COL), .BW_PSUM(BW), .SUM_BW(SBW), .Q_BW(QBW)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_sign_mode (i_sign_mode),
        .i_in_psum   (i_in_psum),
        .i_in_sum    (i_in_sum),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_out_q     (o_out_q),
        .o_out_div0  (o_out_div0),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latency counts clock edges after the accepting edge; a zero divisor shows its result
    // directly in the cycle following acceptance.
    function automatic exp_t model(input logic [COL*BW-1:0] p, input logic [SBW-1:0] s,
                                   input logic sm);
        exp_t e;
        e.div0 = (s == 0);
        e.lat  = (s == 0) ? 0 : COL * D;
        e.q    = '0;
        for (int i = 0; i < COL; i++) begin
            logic [BW-1:0] el;
            longint mag;
            longint qq;
            el = p[i*BW +: BW];
            if (sm && el[BW-1]) mag = longint'(4096) - longint'(el);
            else                mag = longint'(el);
            if (s == 0) qq = 255;
            else        qq = (mag * 256) / longint'(s);
            if (qq > 255) qq = 255;
            e.q[i*QBW +: QBW] = qq[7:0];
        end
        return e;
    endfunction

    task automatic send(input logic [COL*BW-1:0] p, input logic [SBW-1:0] s, input logic sm);
        int n;
        i_in_psum   = p;
        i_in_sum    = s;
        i_sign_mode = sm;
        i_in_valid  = 1'b1;
        n = 0;
        while (o_in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", o_in_ready, 1'b1);
        sb.push_back(model(p, s, sm));
        @(negedge clk);
        acc_cyc     = cyc;
        i_in_valid  = 1'b0;
        i_in_psum   = {$urandom, $urandom, $urandom};
        i_in_sum    = SBW'($urandom);
        i_sign_mode = ~sm;
    endtask

    task automatic get_out(input int hold, input bit junk);
        int   n;
        bit   rdy_bad;
        bit   stable_bad;
        exp_t e;
        logic [COL*QBW-1:0] q0;
        n = 0;
        rdy_bad = 0;
        stable_bad = 0;
        while (o_out_valid !== 1'b1 && n < 400) begin
            if (junk) begin
                if (o_in_ready !== 1'b0) rdy_bad = 1;
                i_in_valid  = 1'($urandom_range(0, 1));
                i_in_psum   = {$urandom, $urandom, $urandom};
                i_in_sum    = SBW'($urandom);
                i_out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        chk("out_valid_seen", o_out_valid, 1'b1);
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("latency", cyc - acc_cyc, e.lat);
            chk("out_q", o_out_q, e.q);
            chk("out_div0", o_out_div0, e.div0);
        end
        q0 = o_out_q;
        for (int k = 0; k < hold; k++) begin
            if (junk) i_in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_out_q !== q0 || o_out_valid !== 1'b1) stable_bad = 1;
            if (o_in_ready !== 1'b0) rdy_bad = 1;
        end
        i_in_valid = 1'b0;
        if (hold > 0) chk("hold_stable", stable_bad, 1'b0);
        if (junk)     chk("ignore_in_ready", rdy_bad, 1'b0);
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        chk("post_xfer_valid", o_out_valid, 1'b0);
        chk("post_xfer_ready", o_in_ready, 1'b1);
    endtask

    initial begin
        logic [COL*BW-1:0] p;
        i_reset     = 1'b1;
        i_sign_mode = 1'b0;
        i_in_psum   = '0;
        i_in_sum    = '0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", o_in_ready, 1'b0);
        chk("rst_out_valid", o_out_valid, 1'b0);
        chk("rst_out_q", o_out_q, '0);
        chk("rst_div0", o_out_div0, 1'b0);
        i_reset = 1'b0;
        #1;
        chk("rst_release_ready", o_in_ready, 1'b1);

        // uniform vector: 16*256/64 = 64
        send({COL{12'd16}}, 19'd64, 1'b0);
        get_out(0, 0);

        // saturation and ratio
        p = '0;
        p[11:0]  = 12'd100;
        p[23:12] = 12'd1;
        send(p, 19'd50, 1'b0);
        get_out(0, 0);

        send({COL{12'hFE0}}, 19'd128, 1'b1);
        get_out(0, 0);
        send({COL{12'hFE0}}, 19'd128, 1'b0);
        get_out(0, 0);
        send({COL{12'h800}}, 19'd2048, 1'b1);
        get_out(0, 0);

        // divide by zero, then a normal vector clears the flag
        send({COL{12'd16}}, 19'd0, 1'b0);
        get_out(0, 0);
        send({COL{12'd16}}, 19'd64, 1'b0);
        get_out(0, 0);

        // backpressure with ignored input pulses on a mixed signed vector
        p = {12'd5, 12'hFFF, 12'd2047, 12'h801, 12'd300, 12'hF00, 12'd0, 12'd77};
        send(p, 19'd1000, 1'b1);
        get_out(20, 1);

        // reset 50 cycles into DIV aborts the vector
        send({COL{12'd123}}, 19'd321, 1'b0);
        repeat (50) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", o_in_ready, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("midrst_ready", o_in_ready, 1'b1);
        chk("midrst_valid", o_out_valid, 1'b0);
        chk("midrst_out_q", o_out_q, '0);
        chk("midrst_div0", o_out_div0, 1'b0);
        void'(sb.pop_back());
        send({COL{12'd40}}, 19'd3000, 1'b0);
        get_out(0, 0);

        for (int r = 0; r < 3; r++) begin
            send({$urandom, $urandom, $urandom}, SBW'($urandom_range(1, 5000)),
                 1'($urandom_range(0, 1)));
            get_out(2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
